// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception controller.
// Optional build macro: EXC_CTRL_VEC_TIMEOUT_EN (vector-fetch ack timeout).
package exc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_VEC_REQ  = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_HANDLER  = 3'd4,
        ST_RETURN   = 3'd5,
        ST_HALT     = 3'd6
    } state_t;

    localparam logic [2:0] CAUSE_NONE = 3'd0;
    localparam logic [2:0] CAUSE_1    = 3'd1;
    localparam logic [2:0] CAUSE_2    = 3'd2;
    localparam logic [2:0] CAUSE_3    = 3'd3;
    localparam logic [2:0] CAUSE_4    = 3'd4;
    localparam logic [2:0] CAUSE_5    = 3'd5;
    localparam logic [2:0] CAUSE_6    = 3'd6;

    localparam logic [31:0] VEC_BASE    = 32'h0000_0000;
    localparam int          ACK_TIMEOUT = 15;

    localparam logic [3:0] FLUSH_NONE  = 4'b0000;
    localparam logic [3:0] FLUSH_IF    = 4'b0001;
    localparam logic [3:0] FLUSH_ID_UP = 4'b0011;
    localparam logic [3:0] FLUSH_EX_UP = 4'b0111;
    localparam logic [3:0] FLUSH_ALL   = 4'b1111;

    // Oldest faulting stage decides how deep the flush reaches.
    function automatic logic [3:0] detect_mask(input logic id, input logic ex, input logic mem);
        if (mem)     return FLUSH_ALL;
        else if (ex) return FLUSH_EX_UP;
        else if (id) return FLUSH_ID_UP;
        else         return FLUSH_NONE;
    endfunction

endpackage

// File: rtl/exc_vec_fetch.sv
// Vector-table read: request/ack handshake, handler address capture and
// optional ack timeout (EXC_CTRL_VEC_TIMEOUT_EN).
module exc_vec_fetch
    import exc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [2:0]  cause_i,
    input  logic        ack_i,
    input  logic [31:0] data_i,
    output logic        vec_req_o,
    output logic [31:0] vec_addr_o,
    output logic        done_o,
    output logic [31:0] handler_o,
    output logic        timeout_o
);

    logic [31:0] handler_q, handler_d;

    assign vec_req_o  = req_i;
    assign vec_addr_o = req_i ? (VEC_BASE + {29'd0, cause_i}) : 32'd0;
    assign done_o     = req_i & ack_i;
    assign handler_o  = handler_q;

    always_comb begin
        handler_d = handler_q;
        if (req_i && ack_i) handler_d = data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) handler_q <= 32'd0;
        else       handler_q <= handler_d;
    end

`ifdef EXC_CTRL_VEC_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;

    // cnt_q counts completed request cycles; the ACK_TIMEOUT-th one without ack fires.
    always_comb begin
        cnt_d = req_i ? (cnt_q + 4'd1) : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 4'd0;
        else       cnt_q <= cnt_d;
    end

    assign timeout_o = req_i & ~ack_i & (cnt_q == 4'(ACK_TIMEOUT - 1));
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/exc_ctrl.sv
// Precise-exception controller: flush, vector fetch, redirect, handler and
// return sequencing with sticky double-fault halt. Macro: EXC_CTRL_VEC_TIMEOUT_EN.
module exc_ctrl
    import exc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_id_in,
    input  logic        exc_ex_in,
    input  logic        exc_mem_in,
    input  logic [2:0]  cause_in,
    input  logic [31:0] epc_in,
    input  logic        eret_in,
    output logic        vec_req_out,
    output logic [31:0] vec_addr_out,
    input  logic        vec_ack_in,
    input  logic [31:0] vec_data_in,
    output logic [3:0]  flush_out,
    output logic        stall_out,
    output logic        pc_load_out,
    output logic [31:0] pc_target_out,
    output logic        in_handler_out,
    output logic [2:0]  cause_out,
    output logic [31:0] epc_out,
    output logic        fault_out
);

    state_t      state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic [2:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    logic        any_exc;
    logic        fetch_active;
    logic        fetch_done;
    logic        fetch_timeout;
    logic [31:0] handler_addr;

    assign any_exc      = exc_id_in | exc_ex_in | exc_mem_in;
    // Driven from the registered state so timeout/done never loop back combinationally.
    assign fetch_active = (state_q == ST_VEC_REQ);

    exc_vec_fetch u_vec_fetch (
        .clk        (clk),
        .reset      (reset),
        .req_i      (fetch_active),
        .cause_i    (cause_q),
        .ack_i      (vec_ack_in),
        .data_i     (vec_data_in),
        .vec_req_o  (vec_req_out),
        .vec_addr_o (vec_addr_out),
        .done_o     (fetch_done),
        .handler_o  (handler_addr),
        .timeout_o  (fetch_timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mask_q  <= FLUSH_NONE;
            cause_q <= CAUSE_NONE;
            epc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        cause_d        = cause_q;
        epc_d          = epc_q;
        flush_out      = FLUSH_NONE;
        stall_out      = 1'b0;
        pc_load_out    = 1'b0;
        pc_target_out  = 32'd0;
        in_handler_out = 1'b0;
        fault_out      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_exc) begin
                    state_d = ST_FLUSH;
                    mask_d  = detect_mask(exc_id_in, exc_ex_in, exc_mem_in);
                end
            end
            ST_FLUSH: begin
                flush_out = mask_q;
                stall_out = 1'b1;
                // Detector registers have settled one cycle after the flag.
                cause_d   = cause_in;
                epc_d     = epc_in;
                state_d   = any_exc ? ST_HALT : ST_VEC_REQ;
            end
            ST_VEC_REQ: begin
                stall_out = 1'b1;
                if (any_exc || fetch_timeout) state_d = ST_HALT;
                else if (fetch_done)          state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                pc_load_out   = 1'b1;
                pc_target_out = handler_addr;
                flush_out     = FLUSH_IF;
                state_d       = any_exc ? ST_HALT : ST_HANDLER;
            end
            ST_HANDLER: begin
                in_handler_out = 1'b1;
                if (any_exc)      state_d = ST_HALT;
                else if (eret_in) state_d = ST_RETURN;
            end
            ST_RETURN: begin
                pc_load_out   = 1'b1;
                pc_target_out = epc_q + 32'd1;
                flush_out     = FLUSH_ID_UP;
                state_d       = any_exc ? ST_HALT : ST_IDLE;
            end
            ST_HALT: begin
                fault_out = 1'b1;
                stall_out = 1'b1;
                flush_out = FLUSH_ALL;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cause_out = cause_q;
    assign epc_out   = epc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus pushes expected events, a negedge
// monitor pops and compares them as the DUT presents flush/vector/redirect/fault.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_id_in, exc_ex_in, exc_mem_in;
    logic [2:0]  cause_in;
    logic [31:0] epc_in;
    logic        eret_in;
    logic        vec_req_out;
    logic [31:0] vec_addr_out;
    logic        vec_ack_in;
    logic [31:0] vec_data_in;
    logic [3:0]  flush_out;
    logic        stall_out;
    logic        pc_load_out;
    logic [31:0] pc_target_out;
    logic        in_handler_out;
    logic [2:0]  cause_out;
    logic [31:0] epc_out;
    logic        fault_out;

    exc_ctrl dut (
        .clk(clk), .reset(reset),
        .exc_id_in(exc_id_in), .exc_ex_in(exc_ex_in), .exc_mem_in(exc_mem_in),
        .cause_in(cause_in), .epc_in(epc_in), .eret_in(eret_in),
        .vec_req_out(vec_req_out), .vec_addr_out(vec_addr_out),
        .vec_ack_in(vec_ack_in), .vec_data_in(vec_data_in),
        .flush_out(flush_out), .stall_out(stall_out),
        .pc_load_out(pc_load_out), .pc_target_out(pc_target_out),
        .in_handler_out(in_handler_out), .cause_out(cause_out),
        .epc_out(epc_out), .fault_out(fault_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_FLUSH, EV_VREQ, EV_PCLOAD, EV_FAULT} ev_t;
    typedef struct {
        ev_t         kind;
        logic [31:0] a;   // vec_addr / pc_target
        logic [3:0]  b;   // flush mask
        logic [2:0]  c;   // cause_out
        logic [31:0] d;   // epc_out
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input ev_t k, input logic [31:0] a, input logic [3:0] b,
                                 input logic [2:0] c, input logic [31:0] d);
        exp_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c; e.d = d;
        sb.push_back(e);
    endfunction

    task automatic mon_event(input ev_t k);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got event %s, expected none", k.name());
        end else begin
            e = sb.pop_front();
            if (e.kind != k) begin
                n_fail++;
                $display("FAIL sb_order: got event %s, expected %s", k.name(), e.kind.name());
            end else begin
                case (k)
                    EV_FLUSH:  chk("flush_mask", {28'd0, flush_out}, {28'd0, e.b});
                    EV_VREQ:   chk("vec_addr", vec_addr_out, e.a);
                    EV_PCLOAD: begin
                        chk("pc_target", pc_target_out, e.a);
                        chk("pcload_flush", {28'd0, flush_out}, {28'd0, e.b});
                        chk("cause_out", {29'd0, cause_out}, {29'd0, e.c});
                        chk("epc_out", epc_out, e.d);
                    end
                    EV_FAULT: begin
                        chk("fault_flush", {28'd0, flush_out}, 32'hF);
                        chk("fault_stall", {31'd0, stall_out}, 32'd1);
                        chk("fault_no_pcload", {31'd0, pc_load_out}, 32'd0);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // Monitor
    initial begin
        logic prev_vreq, prev_fault;
        prev_vreq  = 1'b0;
        prev_fault = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                if (stall_out && !fault_out && !vec_req_out && flush_out != 4'd0) mon_event(EV_FLUSH);
                if (vec_req_out && !prev_vreq)  mon_event(EV_VREQ);
                if (pc_load_out)                mon_event(EV_PCLOAD);
                if (fault_out && !prev_fault)   mon_event(EV_FAULT);
            end
            prev_vreq  = vec_req_out;
            prev_fault = fault_out;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Detection cycle, then hold cause/epc through FLUSH; returns in the first VEC_REQ cycle.
    task automatic raise(input logic id, input logic ex, input logic mem,
                         input logic [2:0] c, input logic [31:0] e, output int t0);
        t0 = cyc;
        exc_id_in = id; exc_ex_in = ex; exc_mem_in = mem;
        cause_in = c; epc_in = e;
        step();
        exc_id_in = 1'b0; exc_ex_in = 1'b0; exc_mem_in = 1'b0;
        step();
        cause_in = 3'd7; epc_in = 32'hDEAD_BEEF;
    endtask

    task automatic ack_after(input int n, input logic [31:0] data);
        repeat (n) step();
        vec_ack_in = 1'b1; vec_data_in = data;
        step();
        vec_ack_in = 1'b0; vec_data_in = 32'h0;
    endtask

    task automatic wait_pcload(input int budget, input int t0, input int exp_lat, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pc_load_out) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL %s: got no pc_load_out within %0d cycles, expected latency %0d", name, budget, exp_lat);
        end else chk(name, cyc - t0, exp_lat);
    endtask

    task automatic eret_pulse();
        eret_in = 1'b1;
        step();
        eret_in = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_vreq"},   {31'd0, vec_req_out}, 32'd0);
        chk({tag, "_vaddr"},  vec_addr_out, 32'd0);
        chk({tag, "_flush"},  {28'd0, flush_out}, 32'd0);
        chk({tag, "_stall"},  {31'd0, stall_out}, 32'd0);
        chk({tag, "_pcload"}, {31'd0, pc_load_out}, 32'd0);
        chk({tag, "_target"}, pc_target_out, 32'd0);
        chk({tag, "_inh"},    {31'd0, in_handler_out}, 32'd0);
        chk({tag, "_cause"},  {29'd0, cause_out}, 32'd0);
        chk({tag, "_epc"},    epc_out, 32'd0);
        chk({tag, "_fault"},  {31'd0, fault_out}, 32'd0);
    endtask

    initial begin
        int t0;
        reset = 1'b1;
        exc_id_in = 0; exc_ex_in = 0; exc_mem_in = 0;
        cause_in = 0; epc_in = 0; eret_in = 0;
        vec_ack_in = 0; vec_data_in = 0;
        repeat (3) step();
        reset = 1'b0;
        check_zero("rst");
        step();

        // EX exception, ack two cycles after the request
        push(EV_FLUSH, 0, 4'b0111, 0, 0);
        push(EV_VREQ, 32'h4, 0, 0, 0);
        push(EV_PCLOAD, 32'h200, 4'b0001, 3'd4, 32'h40);
        raise(0, 1, 0, 3'd4, 32'h40, t0);
        ack_after(2, 32'h200);
        wait_pcload(10, t0, 5, "lat_ex");
        step();
        @(negedge clk);
        chk("in_handler", {31'd0, in_handler_out}, 32'd1);
        chk("handler_stall", {31'd0, stall_out}, 32'd0);
        push(EV_PCLOAD, 32'h41, 4'b0011, 3'd4, 32'h40);
        step();
        eret_pulse();
        step();
        // eret outside HANDLER must do nothing
        eret_in = 1'b1;
        step();
        eret_in = 1'b0;
        @(negedge clk);
        chk("idle_eret_pcload", {31'd0, pc_load_out}, 32'd0);
        chk("idle_cause_kept", {29'd0, cause_out}, 32'd4);
        step();

        // ID + MEM together, ack in the request cycle
        push(EV_FLUSH, 0, 4'b1111, 0, 0);
        push(EV_VREQ, 32'h2, 0, 0, 0);
        push(EV_PCLOAD, 32'h300, 4'b0001, 3'd2, 32'h100);
        raise(1, 0, 1, 3'd2, 32'h100, t0);
        ack_after(0, 32'h300);
        wait_pcload(10, t0, 3, "lat_min");
        step();
        push(EV_PCLOAD, 32'h101, 4'b0011, 3'd2, 32'h100);
        eret_pulse();
        step();

        // cause 0 and EPC wrap on return
        push(EV_FLUSH, 0, 4'b0011, 0, 0);
        push(EV_VREQ, 32'h0, 0, 0, 0);
        push(EV_PCLOAD, 32'h80, 4'b0001, 3'd0, 32'hFFFF_FFFF);
        raise(1, 0, 0, 3'd0, 32'hFFFF_FFFF, t0);
        ack_after(1, 32'h80);
        wait_pcload(10, t0, 4, "lat_id");
        step();
        push(EV_PCLOAD, 32'h0, 4'b0011, 3'd0, 32'hFFFF_FFFF);
        eret_pulse();
        step();
        @(negedge clk);
        chk("wrap_idle_stall", {31'd0, stall_out}, 32'd0);
        chk("wrap_idle_pcload", {31'd0, pc_load_out}, 32'd0);
        step();

        // double fault in HANDLER wins over eret; sticky until reset
        push(EV_FLUSH, 0, 4'b0111, 0, 0);
        push(EV_VREQ, 32'h5, 0, 0, 0);
        push(EV_PCLOAD, 32'h900, 4'b0001, 3'd5, 32'h500);
        push(EV_FAULT, 0, 0, 0, 0);
        raise(0, 1, 0, 3'd5, 32'h500, t0);
        ack_after(0, 32'h900);
        wait_pcload(10, t0, 3, "lat_df");
        step();
        exc_mem_in = 1'b1; eret_in = 1'b1;
        step();
        exc_mem_in = 1'b0; eret_in = 1'b0;
        repeat (5) step();
        @(negedge clk);
        chk("halt_sticky_fault", {31'd0, fault_out}, 32'd1);
        chk("halt_sticky_stall", {31'd0, stall_out}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_zero("halt_rst");
        step();

        // reset during the vector handshake
        push(EV_FLUSH, 0, 4'b0111, 0, 0);
        push(EV_VREQ, 32'h6, 0, 0, 0);
        raise(0, 1, 0, 3'd6, 32'h600, t0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("vreq_rst_vreq", {31'd0, vec_req_out}, 32'd0);
        chk("vreq_rst_stall", {31'd0, stall_out}, 32'd0);
        chk("vreq_rst_cause", {29'd0, cause_out}, 32'd0);
        step();

`ifdef EXC_CTRL_VEC_TIMEOUT_EN
        // no ack: timeout forces HALT
        push(EV_FLUSH, 0, 4'b1111, 0, 0);
        push(EV_VREQ, 32'h3, 0, 0, 0);
        push(EV_FAULT, 0, 0, 0, 0);
        raise(0, 0, 1, 3'd3, 32'h1234, t0);
        repeat (16) step();
        @(negedge clk);
        chk("timeout_fault", {31'd0, fault_out}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
`else
        // long ack wait, handled normally after the earlier reset
        push(EV_FLUSH, 0, 4'b1111, 0, 0);
        push(EV_VREQ, 32'h3, 0, 0, 0);
        push(EV_PCLOAD, 32'hABC0, 4'b0001, 3'd3, 32'h1234);
        raise(0, 0, 1, 3'd3, 32'h1234, t0);
        ack_after(40, 32'hABC0);
        wait_pcload(10, t0, 43, "lat_long");
        step();
        push(EV_PCLOAD, 32'h1235, 4'b0011, 3'd3, 32'h1234);
        eret_pulse();
        step();
        @(negedge clk);
        chk("long_no_fault", {31'd0, fault_out}, 32'd0);
`endif

        repeat (2) step();
        chk("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end before time limit");
        $fatal(1);
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  reset, synchronous, active-high.
REQ-003 exc_id_in  in  1  exception raised in decode stage.
REQ-004 exc_ex_in  in  1  exception raised in execute stage.
REQ-005 exc_mem_in  in  1  exception raised in memory stage.
REQ-006 cause_in  in  3  exception number from detector (1..6; 0 = none).
REQ-007 epc_in  in  32  faulting-instruction PC from detector.
REQ-008 eret_in  in  1  return-from-exception instruction decoded.
REQ-009 vec_req_out  out  1  vector-table read request.
REQ-010 vec_addr_out  out  32  vector-table word address.
REQ-011 vec_ack_in  in  1  vector read complete; vec_data_in valid this cycle.
REQ-012 vec_data_in  in  32  handler start address.
REQ-013 flush_out  out  4  per-stage flush; bit0 IF, bit1 ID, bit2 EX, bit3 MEM.
REQ-014 stall_out  out  1  freeze PC and pipeline registers.
REQ-015 pc_load_out  out  1  load pc_target_out into PC this cycle.
REQ-016 pc_target_out  out  32  PC redirect value.
REQ-017 in_handler_out  out  1  handler executing.
REQ-018 cause_out / epc_out  out  3 / 32  latched CAUSE and EPC copies.
REQ-019 fault_out  out  1  double fault; sticky until reset.

Function
REQ-020 FSM states: IDLE, FLUSH, VEC_REQ, REDIRECT, HANDLER, RETURN, HALT.
REQ-021 IDLE: any exc_*_in high -> FLUSH next cycle; otherwise all outputs inactive.
REQ-022 Detection-cycle flush mask registered: MEM -> 4'b1111, EX -> 4'b0111, ID -> 4'b0011; highest stage wins on simultaneous flags.
REQ-023 FLUSH (1 cycle): flush_out = registered mask, stall_out=1, cause_in/epc_in sampled into cause_out/epc_out (one cycle after detection, detector registers settled).
REQ-024 VEC_REQ: vec_req_out=1, vec_addr_out = VEC_BASE + cause_out zero-extended, stall_out=1; stays until vec_ack_in.
REQ-025 vec_ack_in in VEC_REQ -> REDIRECT; vec_data_in registered as handler address.
REQ-026 REDIRECT (1 cycle): pc_load_out=1, pc_target_out = handler address, flush_out=4'b0001, stall_out=0.
REQ-027 HANDLER: in_handler_out=1, stall_out=0; eret_in -> RETURN.
REQ-028 RETURN (1 cycle): pc_load_out=1, pc_target_out = epc_out + 1 (32-bit wrap), flush_out=4'b0011; -> IDLE; cause_out/epc_out retained.
REQ-029 Any exc_*_in in FLUSH, VEC_REQ, REDIRECT, HANDLER, RETURN -> HALT (double fault); takes priority over eret_in.
REQ-030 HALT: fault_out=1, stall_out=1, flush_out=4'b1111, no exit except reset.
REQ-031 eret_in outside HANDLER ignored; exc inputs with cause_in=0 still handled, vector address = VEC_BASE.
REQ-032 Latency detection -> pc_load_out = 3 cycles + ack wait (ack same cycle as request -> 3).

Reset
REQ-033 reset high at a clock edge: state IDLE; all outputs 0, including cause_out, epc_out, fault_out, mid-handshake or in HALT.
REQ-034 reset overrides all inputs in the same cycle; vec_req_out drops the following cycle.

Configuration
REQ-035 EXC_CTRL_VEC_TIMEOUT_EN defined: 4-bit counter in VEC_REQ; ACK_TIMEOUT (15) cycles without vec_ack_in -> HALT, fault_out=1.
REQ-036 Not defined: VEC_REQ waits indefinitely; no counter logic synthesized.

Structure
REQ-037 exc_ctrl_pkg holds: state enum, cause codes 0..6, VEC_BASE = 32'h0000_0000, ACK_TIMEOUT = 15, flush-mask constants.
REQ-038 One sub-module: exc_vec_fetch (request/ack handshake, data capture, optional timeout); FSM and flush logic stay in exc_ctrl.

Verification
REQ-039 exc_ex_in=1, cause_in=4, epc_in=0x40, ack after 2 cycles, vec_data_in=0x200 -> flush_out 0111, vec_addr_out=4, pc_load_out with target 0x200 on cycle 5, cause_out=4, epc_out=0x40.
REQ-040 exc_id_in and exc_mem_in together -> flush_out=1111.
REQ-041 In HANDLER, eret_in with epc_out=0xFFFFFFFF -> pc_target_out=0x0, return to IDLE.
REQ-042 exc_mem_in during HANDLER -> HALT, fault_out=1 persists until reset; reset -> all outputs 0.
REQ-043 Macro on, no ack 15 cycles -> fault_out=1; macro off, ack after 40 cycles -> normal REDIRECT.
REQ-044 reset asserted in VEC_REQ -> IDLE next cycle, vec_req_out=0, later exception handled normally.
